nn_infer_sequencer: RTL and testbench

Controller that runs one full inference of the two-layer MLP: it clears and steps the layer-1 matmul chain (1×784 · 784×110), then the layer-2 chain (1×110 · 110×10), then scans the 10 output sums for the argmax digit. It sits between the top-level glue and the two matmul datapaths. It drives the shared read index for the image/weight RAMs and the accumulate enables, and hands the classified digit to the 7-segment and VGA logic.

---
 rtl/nn_infer_sequencer.sv | 161 ++++++++++++++++
 tb/tb_nn_infer_sequencer.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/nn_infer_sequencer.sv
// nn_infer_sequencer: steps the two MLP matmul chains, then argmaxes the 10 output sums.
// Optional NN_SEQ_AUTORUN_EN: DONE loops straight back to CLR1 for continuous classification.
module nn_infer_sequencer #(
   parameter int COLS1  = 784,
   parameter int ROWS1  = 110,
   parameter int ROWS2  = 10,
   parameter int IDX_W  = 10,
   parameter int SUM_W  = 32,
   parameter int RD_LAT = 1
) (
   input  logic                    clk100_extern,
   input  logic                    reset_in,
   input  logic                    start,
   output logic                    busy,
   output logic                    done,
   output logic                    rd_en,
   output logic [IDX_W-1:0]        rd_idx,
   output logic                    layer,
   output logic                    acc_clr1,
   output logic                    acc_clr2,
   output logic                    acc_en1,
   output logic                    acc_en2,
   output logic [3:0]              out_sel,
   input  logic signed [SUM_W-1:0] out_sum,
   output logic [3:0]              digit,
   output logic                    digit_valid
);
   typedef enum logic [3:0] {IDLE, CLR1, RUN1, DRAIN1, CLR2, RUN2, DRAIN2, ARGMAX, DONE} state_t;
   state_t state_q, state_d;
   logic [IDX_W-1:0] cnt_q, cnt_d, rd_idx_q, rd_idx_d;
   logic signed [SUM_W-1:0] best_val_q, best_val_d;
   logic [3:0] best_idx_q, best_idx_d, out_sel_q, out_sel_d, digit_q, digit_d;
   logic busy_q, busy_d, done_q, done_d, rd_en_q, rd_en_d, layer_q, layer_d;
   logic acc_clr1_q, acc_clr1_d, acc_clr2_q, acc_clr2_d, digit_valid_q, digit_valid_d;
   logic [RD_LAT-1:0] en1_q, en1_d, en2_q, en2_d;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q + 1'b1;
      best_val_d = best_val_q;
      best_idx_d = best_idx_q;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (start) state_d = CLR1;
         end
         CLR1: begin
            cnt_d   = '0;
            state_d = RUN1;
         end
         RUN1: if (cnt_q == IDX_W'(COLS1-1)) begin
            cnt_d   = '0;
            state_d = DRAIN1;
         end
         DRAIN1: if (cnt_q == IDX_W'(RD_LAT-1)) begin
            cnt_d   = '0;
            state_d = CLR2;
         end
         CLR2: begin
            cnt_d   = '0;
            state_d = RUN2;
         end
         RUN2: if (cnt_q == IDX_W'(ROWS1-1)) begin
            cnt_d   = '0;
            state_d = DRAIN2;
         end
         DRAIN2: if (cnt_q == IDX_W'(RD_LAT-1)) begin
            cnt_d   = '0;
            state_d = ARGMAX;
         end
         ARGMAX: begin
            // strict compare so ties keep the lower index
            if (cnt_q == '0 || out_sum > best_val_q) begin
               best_val_d = out_sum;
               best_idx_d = cnt_q[3:0];
            end
            if (cnt_q == IDX_W'(ROWS2-1)) begin
               cnt_d   = '0;
               state_d = DONE;
            end
         end
         DONE: begin
            cnt_d = '0;
`ifdef NN_SEQ_AUTORUN_EN
            state_d = CLR1;
`else
            state_d = IDLE;
`endif
         end
         default: begin
            cnt_d   = '0;
            state_d = IDLE;
         end
      endcase
      busy_d        = state_d != IDLE;
      done_d        = state_d == DONE;
      rd_en_d       = state_d == RUN1 || state_d == RUN2;
      layer_d       = state_d == RUN2;
      rd_idx_d      = rd_en_d ? cnt_d : '0;
      acc_clr1_d    = state_d == CLR1;
      acc_clr2_d    = state_d == CLR2;
      out_sel_d     = state_d == ARGMAX ? cnt_d[3:0] : 4'd0;
      digit_d       = done_d ? best_idx_d : digit_q;
      digit_valid_d = digit_valid_q | done_d;
      en1_d         = en1_q << 1;
      en1_d[0]      = rd_en_q & ~layer_q;
      en2_d         = en2_q << 1;
      en2_d[0]      = rd_en_q & layer_q;
   end

   always_ff @(posedge clk100_extern or negedge reset_in) begin
      if (!reset_in) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         best_val_q    <= '0;
         best_idx_q    <= '0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         rd_en_q       <= 1'b0;
         layer_q       <= 1'b0;
         rd_idx_q      <= '0;
         acc_clr1_q    <= 1'b0;
         acc_clr2_q    <= 1'b0;
         out_sel_q     <= '0;
         digit_q       <= '0;
         digit_valid_q <= 1'b0;
         en1_q         <= '0;
         en2_q         <= '0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         best_val_q    <= best_val_d;
         best_idx_q    <= best_idx_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         rd_en_q       <= rd_en_d;
         layer_q       <= layer_d;
         rd_idx_q      <= rd_idx_d;
         acc_clr1_q    <= acc_clr1_d;
         acc_clr2_q    <= acc_clr2_d;
         out_sel_q     <= out_sel_d;
         digit_q       <= digit_d;
         digit_valid_q <= digit_valid_d;
         en1_q         <= en1_d;
         en2_q         <= en2_d;
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign rd_en       = rd_en_q;
   assign rd_idx      = rd_idx_q;
   assign layer       = layer_q;
   assign acc_clr1    = acc_clr1_q;
   assign acc_clr2    = acc_clr2_q;
   assign acc_en1     = en1_q[RD_LAT-1];
   assign acc_en2     = en2_q[RD_LAT-1];
   assign out_sel     = out_sel_q;
   assign digit       = digit_q;
   assign digit_valid = digit_valid_q;
endmodule

// File: tb/tb_nn_infer_sequencer.sv
// tb_nn_infer_sequencer: timeline model of one inference (phase offsets from the accepted start)
// compared every cycle, plus literal checks of digit, done timing and beat counts.
`timescale 1ns/1ps
module tb_nn_infer_sequencer;
   localparam int C1 = 784, R1 = 110, R2 = 10, L = 1;
   localparam int R2S = 3 + C1 + L;
   localparam int AM  = R2S + R1 + L;
   localparam int TD  = AM + R2;

   logic clk = 0, reset_in = 0, start = 0;
   logic busy, done, rd_en, layer, acc_clr1, acc_clr2, acc_en1, acc_en2, digit_valid;
   logic [9:0] rd_idx;
   logic [3:0] out_sel, digit;
   logic signed [31:0] out_sum;
   logic signed [31:0] vals [10];

   nn_infer_sequencer dut (
      .clk100_extern(clk), .reset_in(reset_in), .start(start), .busy(busy), .done(done),
      .rd_en(rd_en), .rd_idx(rd_idx), .layer(layer), .acc_clr1(acc_clr1), .acc_clr2(acc_clr2),
      .acc_en1(acc_en1), .acc_en2(acc_en2), .out_sel(out_sel), .out_sum(out_sum),
      .digit(digit), .digit_valid(digit_valid)
   );

   assign out_sum = (out_sel < 4'd10) ? vals[out_sel] : 32'sd0;
   always #5 clk = ~clk;

   int cyc = 0, t = 0, m_digit = 0;
   bit m_valid = 0;
   int n_chk = 0, n_fail = 0;
   int done_seen = 0, last_done = 0, en1_seen = 0, en2_seen = 0;

   function automatic int argmax();
      int b = 0;
      for (int i = 1; i < 10; i++) if (vals[i] > vals[b]) b = i;
      return b;
   endfunction

   // t = cycles since the accepted start (0 = idle); a run occupies t = 1..TD
   always @(posedge clk or negedge reset_in) begin
      if (!reset_in) begin
         t = 0;
         m_digit = 0;
         m_valid = 0;
      end else begin
         cyc++;
         if (t != 0) t = (t == TD) ? 0 : t + 1;
         else if (start) t = 1;
         if (t == TD) begin
            m_digit = argmax();
            m_valid = 1;
         end
      end
   end

   function automatic logic [26:0] model_vec(int tt, int dg, bit v);
      bit r1 = tt >= 2 && tt < 2 + C1;
      bit r2 = tt >= R2S && tt < R2S + R1;
      bit am = tt >= AM && tt < TD;
      int idx = r1 ? tt - 2 : (r2 ? tt - R2S : 0);
      int os = am ? tt - AM : 0;
      return {tt != 0, tt == TD, r1 || r2, r2, 10'(idx), tt == 1, tt == 2 + C1 + L,
              tt >= 2 + L && tt < 2 + C1 + L, tt >= R2S + L && tt < R2S + R1 + L,
              4'(os), 4'(dg), v};
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   initial begin
      int s, d0, e1, e2;
      bit found;
      logic signed [31:0] va [10] = '{5, -3, 100, 7, 0, 0, 0, 100, 1, 2};
      for (int i = 0; i < 10; i++) vals[i] = 0;
      fork
         forever begin
            logic [26:0] act, exp;
            @(negedge clk);
            act = {busy, done, rd_en, layer, rd_idx, acc_clr1, acc_clr2, acc_en1, acc_en2,
                   out_sel, digit, digit_valid};
            exp = model_vec(t, m_digit, m_valid);
            n_chk++;
            if (act !== exp) begin
               n_fail++;
               $display("FAIL cycle_model cyc=%0d t=%0d: got %h expected %h", cyc, t, act, exp);
            end
            if (done) begin
               done_seen++;
               last_done = cyc;
            end
            en1_seen += int'(acc_en1);
            en2_seen += int'(acc_en2);
         end
      join_none
      repeat (10) @(posedge clk);
      #1;
      chk("reset_busy", busy, 0);
      chk("reset_rd_idx", rd_idx, 0);
      chk("reset_valid", digit_valid, 0);
      reset_in = 1;
      repeat (1000) @(posedge clk);
      #1;
      chk("idle_busy", busy, 0);
      chk("idle_done_count", done_seen, 0);
      // run A with start filtering, run B accepted in the cycle after DONE
      vals = va;
      s = cyc; d0 = done_seen; e1 = en1_seen; e2 = en2_seen;
      for (int i = 0; i <= 912; i++) begin
         start = i inside {0, 1, 500, 909, 910};
         if (i == 910) for (int k = 0; k < 10; k++) vals[k] = k - 10;
         @(posedge clk);
         #1;
      end
      start = 0;
      chk("runA_done_count", done_seen - d0, 1);
      chk("runA_done_cycle", last_done - s, 909);
      chk("runA_en1_beats", en1_seen - e1, 784);
      chk("runA_en2_beats", en2_seen - e2, 110);
      chk("runA_digit_tie", digit, 2);
      chk("runA_valid", digit_valid, 1);
      repeat (1819 - 913 + 2) @(posedge clk);
      #1;
      chk("runB_done_cycle", last_done - s, 1819);
      chk("runB_done_count", done_seen - d0, 2);
      chk("runB_digit_neg", digit, 9);
      // all-zero sums
      for (int k = 0; k < 10; k++) vals[k] = 0;
      start = 1;
      @(posedge clk);
      #1;
      start = 0;
      repeat (911) @(posedge clk);
      #1;
      chk("runC_digit_zero", digit, 0);
      chk("runC_valid", digit_valid, 1);
      // async reset in the middle of RUN1
      vals = va;
      start = 1;
      @(posedge clk);
      #1;
      start = 0;
      found = 0;
      for (int i = 0; i < 1000 && !found; i++) begin
         @(negedge clk);
         if (rd_idx == 10'd300 && rd_en) found = 1;
      end
      chk("found_idx300", found, 1);
      #2;
      reset_in = 0;
      #1;
      chk("midrst_busy", busy, 0);
      chk("midrst_rd_en", rd_en, 0);
      chk("midrst_rd_idx", rd_idx, 0);
      chk("midrst_acc_en1", acc_en1, 0);
      chk("midrst_digit", digit, 0);
      chk("midrst_valid", digit_valid, 0);
      repeat (3) @(posedge clk);
      #1;
      reset_in = 1;
      @(posedge clk);
      #1;
      start = 1;
      s = cyc;
      @(posedge clk);
      #1;
      start = 0;
      repeat (907) @(posedge clk);
      #1;
      chk("restart_valid_pre", digit_valid, 0);
      @(posedge clk);
      #1;
      chk("restart_cycle", cyc - s, 909);
      chk("restart_done", done, 1);
      chk("restart_valid", digit_valid, 1);
      chk("restart_digit", digit, 2);
      repeat (3) @(posedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
